encrypt_stream_ctrl: RTL and testbench

ENCRYPT_STREAM_CTRL -- requirements
Module: encrypt_stream_ctrl

---
 rtl/encrypt_stream_ctrl.sv | 117 +++++++++++
 tb/tb_encrypt_stream_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_stream_ctrl.sv
// Byte-stream encrypt controller: framed 1-byte/cycle encrypt with skid-free output register.
// Optional running XOR checksum of the encrypted frame when ENC_STREAM_CHECKSUM_EN is defined.

module encrypt_core (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0]  KEY = 8'h6C;
    // Diffusion matrix columns, column i at [8*i +: 8]; invertible over GF(2).
    localparam logic [63:0] MIX = {8'hAF, 8'hFF, 8'h48, 8'hDC,
                                   8'h20, 8'h40, 8'h02, 8'hF1};

    always_comb begin
        dout = KEY;
        for (int i = 0; i < 8; i++) begin
            if (din[i]) dout = dout ^ MIX[8*i +: 8];
        end
    end
endmodule

module encrypt_stream_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [7:0]       m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count,
    output logic [7:0]       chk
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [LEN_W-1:0] rem;
    logic [7:0]       enc;
    logic             xfer;

    encrypt_core u_enc (
        .din  (s_data),
        .dout (enc)
    );

    assign s_ready = (state == RUN) && (!m_valid || m_ready) && (rem != '0);
    assign xfer    = s_valid && s_ready;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            count   <= '0;
            m_valid <= 1'b0;
            m_data  <= 8'h00;
        end else begin
            // A new accept refills the output register in the same cycle it drains.
            if (xfer) begin
                m_valid <= 1'b1;
                m_data  <= enc;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= len;
                        count <= '0;
                        state <= (len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        rem   <= rem - LEN_W'(1);
                        count <= count + LEN_W'(1);
                        if (rem == LEN_W'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!m_valid || m_ready) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ENC_STREAM_CHECKSUM_EN
    logic [7:0] chk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 8'h00;
        end else if (state == IDLE && start) begin
            chk_q <= 8'h00;
        end else if (xfer) begin
            chk_q <= chk_q ^ enc;
        end
    end

    assign chk = chk_q;
`else
    assign chk = 8'h00;
`endif

endmodule

// File: tb/tb_encrypt_stream_ctrl.sv
// Scoreboard bench for encrypt_stream_ctrl: frames, backpressure, len=0,
// ignored start, mid-frame reset. Honors ENC_STREAM_CHECKSUM_EN for chk.

module tb_encrypt_stream_ctrl;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_ready;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_ready;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] count;
    logic [7:0]       chk;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_done = 0;
    logic [7:0] sb[$];
    logic [7:0] pay[4];

    bit         prev_acc = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    encrypt_stream_ctrl #(.LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .chk     (chk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Known plaintext/ciphertext pairs of the encrypt datapath.
    function automatic logic [7:0] exp_enc(input logic [7:0] b);
        case (b)
            8'h00:   return 8'h6C;
            8'h01:   return 8'h9D;
            8'h41:   return 8'h62;
            8'h7E:   return 8'h65;
            8'hA5:   return 8'h3A;
            8'hFF:   return 8'h3B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_acc   = 0;
            prev_stall = 0;
        end else begin
            if (prev_acc) check("latency", m_valid, 1);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) check("sb_extra", 1, 0);
                else check("m_data", m_data, sb.pop_front());
            end
            if (done) n_done++;
            prev_acc = s_valid && s_ready;
            if (prev_acc) sb.push_back(exp_enc(s_data));
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic run_frame(input int flen, input int nb,
                             input int stall_len, input bit poke);
        int         nacc;
        int         sc;
        int         base;
        bit         seen;
        bit         acc;
        logic [7:0] ck;
        nacc = 0;
        sc   = 0;
        seen = 0;
        ck   = 8'h00;
        base = n_done;
`ifdef ENC_STREAM_CHECKSUM_EN
        for (int i = 0; i < nb; i++) ck ^= exp_enc(pay[i]);
`endif
        start   = 1'b1;
        len     = LEN_W'(flen);
        m_ready = 1'b1;
        s_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 64 && !seen; cyc++) begin
            s_valid = (nacc < nb);
            s_data  = s_valid ? pay[nacc % 4] : 8'h00;
            m_ready = !(nacc >= 1 && sc < stall_len);
            start   = poke && (nacc == 1);
            len     = LEN_W'(3);
            @(negedge clk);
            if (!m_ready && m_valid) check("stall_srdy", s_ready, 0);
            acc = s_valid && s_ready;
            if (done) begin
                seen = 1;
                check("frame_cyc", cyc, nb + 1 + stall_len);
                check("done_srdy", s_ready, 0);
                check("done_busy", busy, 1);
                check("done_count", count, flen);
                check("done_chk", chk, ck);
            end
            tick();
            if (acc) nacc++;
            if (!m_ready) sc++;
        end
        if (!seen) check("timeout", 0, 1);
        start   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("end_busy", busy, 0);
        check("done_pulses", n_done - base, 1);
        check("hold_count", count, flen);
        check("hold_chk", chk, ck);
        check("sb_drained", sb.size(), 0);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst     = 1'b1;
        start   = 1'b1;
        len     = LEN_W'(5);
        s_valid = 1'b1;
        s_data  = 8'h41;
        m_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_srdy", s_ready, 0);
        check("rst_count", count, 0);
        check("rst_chk", chk, 0);
        check("rst_done", done, 0);
        check("rst_mdata", m_data, 0);
        tick();
        rst     = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        tick();

        pay[0] = 8'h00; pay[1] = 8'h01; pay[2] = 8'h41; pay[3] = 8'h00;
        run_frame(3, 3, 0, 0);

        pay[0] = 8'h7E; pay[1] = 8'hA5;
        run_frame(2, 2, 4, 0);

        start   = 1'b1;
        len     = '0;
        s_valid = 1'b1;
        s_data  = 8'h00;
        base    = n_done;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_srdy", s_ready, 0);
        check("len0_count", count, 0);
        check("len0_chk", chk, 0);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("len0_pulse", done, 0);
        check("len0_busy", busy, 0);
        check("len0_ndone", n_done - base, 1);
        tick();

        pay[0] = 8'hFF; pay[1] = 8'h00;
        run_frame(2, 2, 0, 1);

        start   = 1'b1;
        len     = LEN_W'(3);
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h00;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("mr_pending", m_valid, 1);
        base = n_done;
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mr_mvalid", m_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_srdy", s_ready, 0);
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        sb.delete();
        tick();
        @(negedge clk);
        check("mr_idle", busy, 0);
        check("mr_nodone", n_done - base, 0);
        tick();

        pay[0] = 8'h00;
        run_frame(1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
